// File: rtl/seq_det_ctrl.sv
// Programmable overlapping serial pattern detector with config/arm/run/done sequencing.
// Optional build macro SEQ_DET_MASK_EN adds a per-bit don't-care mask (cfg_mask).
module seq_det_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [CNT_W-1:0] cfg_target,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_W-1:0] cfg_mask,
`endif
  input  logic             start,
  input  logic             abort,
  input  logic             data_valid,
  input  logic             data_in,
  output logic             detected,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             done
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_reg;
  logic [PAT_W-1:0]  history_reg;
  logic [PAT_W-1:0]  pattern_reg;
  logic [CNT_W-1:0]  target_reg;
  logic [FILL_W-1:0] fill_reg;
  logic [PAT_W-1:0]  mask_eff;

`ifdef SEQ_DET_MASK_EN
  logic [PAT_W-1:0]  mask_reg;
  assign mask_eff = mask_reg;
`else
  assign mask_eff = '0;
`endif

  logic [PAT_W-1:0]  history_next;
  logic [FILL_W-1:0] fill_next;
  logic [PAT_W-1:0]  bit_ok;
  logic [CNT_W-1:0]  count_plus;
  logic [CNT_W-1:0]  count_next;
  logic              match_hit;
  logic              target_hit;
  logic              handshake;
  logic              can_start;

  assign history_next = {history_reg[PAT_W-2:0], data_in};
  assign fill_next    = (fill_reg == FILL_FULL) ? fill_reg : fill_reg + FILL_W'(1);

  // Per-bit compare against the post-shift history; masked bits always agree.
  genvar gi;
  generate
    for (gi = 0; gi < PAT_W; gi++) begin : g_cmp
      assign bit_ok[gi] = mask_eff[gi] | (history_next[gi] ~^ pattern_reg[gi]);
    end
  endgenerate

  assign match_hit  = (fill_next == FILL_FULL) && (&bit_ok);
  assign count_plus = match_count + CNT_W'(1);
  assign count_next = (&match_count) ? match_count : count_plus;
  assign target_hit = (target_reg != '0) && (count_plus == target_reg);
  assign handshake  = cfg_valid && cfg_ready;
  assign can_start  = (state_reg == S_ARMED) || (state_reg == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= S_IDLE;
      history_reg <= '0;
      pattern_reg <= '0;
      target_reg  <= '0;
      fill_reg    <= '0;
`ifdef SEQ_DET_MASK_EN
      mask_reg    <= '0;
`endif
      cfg_ready   <= 1'b1;
      detected    <= 1'b0;
      match_count <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      detected <= 1'b0;
      if (abort) begin
        state_reg <= S_IDLE;
        cfg_ready <= 1'b1;
        busy      <= 1'b0;
        done      <= 1'b0;
      end else if (handshake) begin
        state_reg   <= S_ARMED;
        pattern_reg <= cfg_pattern;
        target_reg  <= cfg_target;
`ifdef SEQ_DET_MASK_EN
        mask_reg    <= cfg_mask;
`endif
        cfg_ready   <= 1'b0;
        busy        <= 1'b0;
        done        <= 1'b0;
      end else if (start && can_start) begin
        state_reg   <= S_RUN;
        match_count <= '0;
        history_reg <= '0;
        fill_reg    <= '0;
        cfg_ready   <= 1'b0;
        busy        <= 1'b1;
        done        <= 1'b0;
      end else if (state_reg == S_RUN && data_valid) begin
        history_reg <= history_next;
        fill_reg    <= fill_next;
        if (match_hit) begin
          detected    <= 1'b1;
          match_count <= count_next;
          // Reaching the target freezes the run; later bits are ignored.
          if (target_hit) begin
            state_reg <= S_DONE;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
      end
    end
  end

endmodule
